nv_ram_fifo_ctrl_128x128: RTL and testbench
===========================================

NV_RAM_FIFO_CTRL_128X128 -- requirements
Module: nv_ram_fifo_ctrl_128x128

Interface
REQ-001 The block SHALL have no parameters; depth is fixed at 128 RAM entries by 128 bits.
REQ-002 nvdla_core_clk  input  1  sole clock; all state SHALL be on its rising edge.
REQ-003 nvdla_core_rstn  input  1  reset, asynchronous assert, active-low.
REQ-004 wr_pvld  input  1  write-side data valid.
REQ-005 wr_prdy  output  1  write-side ready.
REQ-006 wr_pd  input  128  write payload.
REQ-007 rd_pvld  output  1  read-side data valid.
REQ-008 rd_prdy  input  1  read-side ready.
REQ-009 rd_pd  output  128  read payload.
REQ-010 ram_we  output  1  RAM write enable.
REQ-011 ram_wa  output  7  RAM write address.
REQ-012 ram_di  output  128  RAM write data.
REQ-013 ram_re  output  1  RAM read enable; the RAM registers ram_ra when ram_re=1.
REQ-014 ram_ra  output  7  RAM read address.
REQ-015 ram_dout  input  128  RAM read data, valid the cycle after ram_re=1 and held until the next ram_re.
REQ-016 fifo_cnt  output  8  total entries held (RAM + in-flight + output stage), range 0..130; width 8 suffices.
REQ-017 fifo_idle  output  1  high when fifo_cnt==0.

Function
REQ-018 Push SHALL occur when wr_pvld && wr_prdy; push drives ram_we=1, ram_wa=wr_ptr, ram_di=wr_pd in the same cycle (combinational), and wr_ptr SHALL increment mod 128.
REQ-019 wr_prdy SHALL be 1 iff ram_cnt<128, with no same-cycle credit from a concurrent RAM read, so ram_wa never equals an unread entry.
REQ-020 ram_cnt (0..128) SHALL increment on push, decrement on read issue, and be unchanged when both occur together.
REQ-021 Output stage: a 2-entry skid buffer (out_cnt 0..2) plus a 1-bit in-flight flag.
REQ-022 Pop SHALL occur when rd_pvld && rd_prdy; rd_pvld SHALL be 1 iff out_cnt>0; rd_pd SHALL be the oldest output-stage entry.
REQ-023 Read issue in cycle t SHALL occur iff ram_cnt>0 && (out_cnt + inflight - pop_t) < 2; issue drives ram_re=1, ram_ra=rd_ptr, sets inflight for cycle t+1, and rd_ptr SHALL increment mod 128.
REQ-024 In cycle t+1, ram_dout SHALL be captured into the output stage at the closing edge; a concurrent push to the same address in t+1 SHALL NOT corrupt the capture.
REQ-025 Sustained throughput SHALL be one entry per cycle once the output stage is primed; empty-to-first-rd_pvld latency SHALL be 2 cycles after the push edge.
REQ-026 Simultaneous push, issue, capture and pop in one cycle SHALL all be honoured and counters SHALL stay consistent.
REQ-027 Ordering SHALL be strict FIFO across the RAM and output stage.
REQ-028 fifo_cnt SHALL equal ram_cnt + inflight + out_cnt, registered, and SHALL NOT exceed 130.
REQ-029 ram_we and ram_re SHALL never be 1 without a corresponding push or issue; ram_wa and ram_ra SHALL be don't-care otherwise but driven from the pointers.
REQ-030 A payload that changes while wr_pvld=1 && wr_prdy=0 SHALL NOT be written to the RAM.

Reset
REQ-031 While nvdla_core_rstn=0: wr_ptr=rd_ptr=0, ram_cnt=0, out_cnt=0, inflight=0, rd_pvld=0, ram_we=0, ram_re=0, fifo_cnt=0, fifo_idle=1, and wr_prdy=1 after release.
REQ-032 Reset asserted mid-operation SHALL discard all contents, including any in-flight read; RAM contents are not cleared.
REQ-033 Output-stage data registers SHALL need no reset; rd_pd is undefined while rd_pvld=0.

Verification
REQ-034 Single push of 0xA5..A5 into an empty FIFO with rd_prdy=1 -> ram_we in the push cycle, ram_re the next cycle, rd_pvld=1 with rd_pd=0xA5..A5 two cycles after the push, then fifo_idle=1.
REQ-035 130 pushes with rd_prdy=0 -> wr_prdy=0 after 130 accepted pushes, fifo_cnt=130; then rd_prdy=1 -> 130 pops in order, one per cycle after the first, and wr_prdy reasserts the cycle after the first issue.
REQ-036 Continuous push and pop for 1000 cycles with incrementing data -> no gaps after priming, in-order data, and fifo_cnt stable at steady state.
REQ-037 Random wr_pvld/rd_prdy at 50% each for 10k cycles against a reference queue -> data match, and fifo_cnt always equals the model occupancy.
REQ-038 Pointer wrap: 300 entries streamed with occupancy near 128 -> wr_ptr and rd_ptr wrap from 127 to 0 with no data loss, and no ram_we to an unread address.
REQ-039 Reset asserted with fifo_cnt=50 and a read in flight -> all outputs take their reset values immediately, and a following single push or pop behaves as in REQ-034.

Source files
------------

// File: rtl/nv_ram_fifo_ctrl_128x128.sv
// Controller for a 128x128 FIFO backed by an external RAM with a registered read port.
// A 2-entry output skid stage plus one in-flight read hide the RAM read latency.
module nv_ram_fifo_ctrl_128x128 (
  input  logic         nvdla_core_clk,
  input  logic         nvdla_core_rstn,
  input  logic         wr_pvld,
  output logic         wr_prdy,
  input  logic [127:0] wr_pd,
  output logic         rd_pvld,
  input  logic         rd_prdy,
  output logic [127:0] rd_pd,
  output logic         ram_we,
  output logic [6:0]   ram_wa,
  output logic [127:0] ram_di,
  output logic         ram_re,
  output logic [6:0]   ram_ra,
  input  logic [127:0] ram_dout,
  output logic [7:0]   fifo_cnt,
  output logic         fifo_idle
);

  // Handshakes: a beat transfers on a rising edge where valid && ready are both 1;
  // valid never depends on ready on either side.

  logic [6:0]   wr_ptr;
  logic [6:0]   rd_ptr;
  logic [7:0]   ram_cnt;
  logic [1:0]   out_cnt;
  logic         inflight;
  logic [127:0] out_q0;
  logic [127:0] out_q1;
  logic         push;
  logic         pop;
  logic         issue;
  logic [2:0]   stage_after_pop;

  // No credit from a same-cycle read: a write never lands on an unread entry.
  assign wr_prdy = nvdla_core_rstn && (ram_cnt < 8'd128);
  assign push    = wr_pvld && wr_prdy;
  assign rd_pvld = (out_cnt != 2'd0);
  assign pop     = rd_pvld && rd_prdy;

  assign stage_after_pop = {1'b0, out_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign issue           = (ram_cnt != 8'd0) && (stage_after_pop < 3'd2);

  assign ram_we    = push;
  assign ram_wa    = wr_ptr;
  assign ram_di    = wr_pd;
  assign ram_re    = issue;
  assign ram_ra    = rd_ptr;
  assign rd_pd     = out_q0;
  assign fifo_idle = (fifo_cnt == 8'd0);

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr   <= 7'd0;
      rd_ptr   <= 7'd0;
      ram_cnt  <= 8'd0;
      out_cnt  <= 2'd0;
      inflight <= 1'b0;
      fifo_cnt <= 8'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 7'd1;
      end
      if (issue) begin
        rd_ptr <= rd_ptr + 7'd1;
      end
      case ({push, issue})
        2'b10:   ram_cnt <= ram_cnt + 8'd1;
        2'b01:   ram_cnt <= ram_cnt - 8'd1;
        default: ram_cnt <= ram_cnt;
      endcase
      inflight <= issue;
      out_cnt  <= out_cnt + {1'b0, inflight} - {1'b0, pop};
      // Issue and capture only move entries inside the FIFO, so the total tracks push/pop.
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 8'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 8'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Output-stage data carries no reset; rd_pvld qualifies it.
  always_ff @(posedge nvdla_core_clk) begin
    case ({inflight, pop})
      2'b01: begin
        out_q0 <= out_q1;
      end
      2'b10: begin
        if (out_cnt == 2'd0) begin
          out_q0 <= ram_dout;
        end else begin
          out_q1 <= ram_dout;
        end
      end
      2'b11: begin
        if (out_cnt == 2'd1) begin
          out_q0 <= ram_dout;
        end else begin
          out_q0 <= out_q1;
          out_q1 <= ram_dout;
        end
      end
      default: begin
        out_q0 <= out_q0;
        out_q1 <= out_q1;
      end
    endcase
  end

endmodule

// File: tb/tb_nv_ram_fifo_ctrl_128x128.sv
// Bench for nv_ram_fifo_ctrl_128x128: behavioural RAM, queue-based reference model
// checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_nv_ram_fifo_ctrl_128x128;

  logic         clk;
  logic         rstn;
  logic         wr_pvld;
  logic         wr_prdy;
  logic [127:0] wr_pd;
  logic         rd_pvld;
  logic         rd_prdy;
  logic [127:0] rd_pd;
  logic         ram_we;
  logic [6:0]   ram_wa;
  logic [127:0] ram_di;
  logic         ram_re;
  logic [6:0]   ram_ra;
  logic [127:0] ram_dout;
  logic [7:0]   fifo_cnt;
  logic         fifo_idle;

  int n_checks = 0;
  int n_errors = 0;
  int data_ctr = 0;

  logic [127:0] exp_q[$];
  int           m_ram;
  logic [6:0]   m_wp;
  logic [6:0]   m_rp;
  logic         m_infl;

  logic [127:0] mem [128];

  nv_ram_fifo_ctrl_128x128 dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rstn(rstn),
    .wr_pvld        (wr_pvld),
    .wr_prdy        (wr_prdy),
    .wr_pd          (wr_pd),
    .rd_pvld        (rd_pvld),
    .rd_prdy        (rd_prdy),
    .rd_pd          (rd_pd),
    .ram_we         (ram_we),
    .ram_wa         (ram_wa),
    .ram_di         (ram_di),
    .ram_re         (ram_re),
    .ram_ra         (ram_ra),
    .ram_dout       (ram_dout),
    .fifo_cnt       (fifo_cnt),
    .fifo_idle      (fifo_idle)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run did not end, act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  // Registered-read RAM: read samples the old contents on a same-edge write.
  always @(posedge clk) begin
    if (ram_re) ram_dout <= mem[ram_ra];
    if (ram_we) mem[ram_wa] <= ram_di;
  end

  // ---------------- helpers / driver tasks ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: act=%h req=%h", name, $time, act, exp);
    end
  endtask

  function automatic logic [127:0] pat(input int n);
    return {32'hC0DE_0000 | 32'(n & 16'hFFFF), 32'(n), ~32'(n), 32'(n * 7)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input int n, input logic rdy, output int acc);
    acc = 0;
    rd_prdy = rdy;
    for (int i = 0; i < n * 4 && acc < n; i++) begin
      tick();
      wr_pvld = 1'b1;
      wr_pd   = pat(data_ctr);
      @(negedge clk);
      if (wr_prdy) begin
        acc++;
        data_ctr++;
      end
    end
    tick();
    wr_pvld = 1'b0;
  endtask

  task automatic drain(input string name);
    wr_pvld = 1'b0;
    rd_prdy = 1'b1;
    for (int i = 0; i < 400 && !(fifo_idle && !rd_pvld); i++) tick();
    @(negedge clk);
    chk(name, fifo_idle, 1'b1);
    tick();
  endtask

  task automatic single_push_check(input string tag);
    tick();
    wr_pvld = 1'b1;
    wr_pd   = {16{8'hA5}};
    rd_prdy = 1'b1;
    @(negedge clk);
    chk({tag, "_we_push_cycle"}, ram_we, 1'b1);
    tick();
    wr_pvld = 1'b0;
    @(negedge clk);
    chk({tag, "_re_next_cycle"}, ram_re, 1'b1);
    chk({tag, "_pvld_c1"}, rd_pvld, 1'b0);
    tick();
    @(negedge clk);
    chk({tag, "_pvld_c2"}, rd_pvld, 1'b0);
    chk({tag, "_cnt_c2"}, fifo_cnt, 8'd1);
    tick();
    @(negedge clk);
    chk({tag, "_pvld_c3"}, rd_pvld, 1'b1);
    chk({tag, "_pd_c3"}, rd_pd, {16{8'hA5}});
    tick();
    @(negedge clk);
    chk({tag, "_idle_after"}, fifo_idle, 1'b1);
    chk({tag, "_cnt_after"}, fifo_cnt, 8'd0);
  endtask

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin : compare
    int   out_n;
    logic e_prdy, e_pvld, e_pop, e_push, e_issue;
    if (!rstn) begin
      chk("rst_rd_pvld", rd_pvld, 1'b0);
      chk("rst_ram_we", ram_we, 1'b0);
      chk("rst_ram_re", ram_re, 1'b0);
      chk("rst_fifo_cnt", fifo_cnt, 8'd0);
      chk("rst_fifo_idle", fifo_idle, 1'b1);
      exp_q.delete();
      m_ram  = 0;
      m_wp   = 7'd0;
      m_rp   = 7'd0;
      m_infl = 1'b0;
    end else begin
      // Entries not in RAM and not in flight sit in the output stage.
      out_n   = exp_q.size() - m_ram - int'(m_infl);
      e_prdy  = (m_ram < 128);
      e_pvld  = (out_n > 0);
      e_pop   = e_pvld && rd_prdy;
      e_push  = wr_pvld && e_prdy;
      e_issue = (m_ram > 0) && ((out_n + int'(m_infl) - int'(e_pop)) < 2);

      chk("wr_prdy", wr_prdy, e_prdy);
      chk("rd_pvld", rd_pvld, e_pvld);
      if (e_pvld) chk("rd_pd_order", rd_pd, exp_q[0]);
      chk("ram_we", ram_we, e_push);
      if (e_push) begin
        chk("ram_wa", ram_wa, m_wp);
        chk("ram_di", ram_di, wr_pd);
      end
      chk("ram_re", ram_re, e_issue);
      if (e_issue) chk("ram_ra", ram_ra, m_rp);
      chk("fifo_cnt", fifo_cnt, 128'(exp_q.size()));
      chk("fifo_idle", fifo_idle, exp_q.size() == 0);

      if (e_push) begin
        exp_q.push_back(wr_pd);
        m_wp  = m_wp + 7'd1;
        m_ram = m_ram + 1;
      end
      if (e_issue) begin
        m_rp  = m_rp + 7'd1;
        m_ram = m_ram - 1;
      end
      m_infl = e_issue;
      if (e_pop) void'(exp_q.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int acc;
    int gaps;
    int bad;
    int total;
    rstn    = 1'b0;
    wr_pvld = 1'b0;
    wr_pd   = '0;
    rd_prdy = 1'b0;
    repeat (3) tick();
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_release_wr_prdy", wr_prdy, 1'b1);
    chk("rst_release_idle", fifo_idle, 1'b1);

    // Single entry through an empty FIFO.
    single_push_check("single");

    // Fill to 130 with the reader stalled, then drain in one burst.
    push_n(130, 1'b0, acc);
    chk("fill_accepted", 128'(acc), 128'd130);
    @(negedge clk);
    chk("full_wr_prdy", wr_prdy, 1'b0);
    chk("full_fifo_cnt", fifo_cnt, 8'd130);
    // Payload churn while stalled must never reach the RAM.
    for (int i = 0; i < 3; i++) begin
      tick();
      wr_pvld = 1'b1;
      wr_pd   = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      chk("stall_no_we", ram_we, 1'b0);
    end
    tick();
    wr_pvld = 1'b0;
    rd_prdy = 1'b1;
    gaps = 0;
    @(negedge clk);
    chk("burst_first_issue", ram_re, 1'b1);
    chk("burst_prdy_still_low", wr_prdy, 1'b0);
    if (!rd_pvld) gaps++;
    tick();
    @(negedge clk);
    chk("burst_prdy_reasserts", wr_prdy, 1'b1);
    if (!rd_pvld) gaps++;
    for (int i = 0; i < 128; i++) begin
      tick();
      @(negedge clk);
      if (!rd_pvld) gaps++;
    end
    chk("burst_no_gaps", 128'(gaps), 128'd0);
    tick();
    @(negedge clk);
    chk("burst_idle_after_130", fifo_idle, 1'b1);

    // Continuous push and pop: three entries in the pipe, no bubbles.
    tick();
    wr_pvld = 1'b1;
    rd_prdy = 1'b1;
    gaps = 0;
    bad  = 0;
    for (int i = 0; i < 1000; i++) begin
      wr_pd = pat(data_ctr);
      @(negedge clk);
      if (wr_prdy) data_ctr++;
      if (i >= 3 && !rd_pvld) gaps++;
      if (i >= 3 && fifo_cnt != 8'd3) bad++;
      tick();
    end
    wr_pvld = 1'b0;
    chk("stream_no_gaps", 128'(gaps), 128'd0);
    chk("stream_cnt_steady", 128'(bad), 128'd0);
    drain("stream_drain");

    // Random traffic, 50% each side.
    for (int i = 0; i < 10000; i++) begin
      wr_pvld = 1'($urandom_range(0, 1));
      rd_prdy = 1'($urandom_range(0, 1));
      wr_pd   = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    drain("random_drain");

    // Pointer wrap with occupancy held near 128.
    push_n(129, 1'b0, acc);
    total = acc;
    tick();
    wr_pvld = 1'b1;
    rd_prdy = 1'b1;
    for (int i = 0; i < 1000 && total < 300; i++) begin
      wr_pd = pat(data_ctr);
      @(negedge clk);
      if (wr_prdy) begin
        data_ctr++;
        total++;
      end
      tick();
    end
    wr_pvld = 1'b0;
    chk("wrap_streamed", 128'(total), 128'd300);
    drain("wrap_drain");

    // Reset mid-operation with 50 entries and a read in flight.
    push_n(50, 1'b0, acc);
    tick();
    wr_pvld = 1'b1;
    wr_pd   = pat(data_ctr);
    rd_prdy = 1'b1;
    @(negedge clk);
    chk("midrst_issue", ram_re, 1'b1);
    tick();
    wr_pvld = 1'b0;
    rd_prdy = 1'b0;
    @(negedge clk);
    chk("midrst_cnt50", fifo_cnt, 8'd50);
    #2;
    rstn = 1'b0;
    #1;
    chk("midrst_pvld", rd_pvld, 1'b0);
    chk("midrst_fifo_cnt", fifo_cnt, 8'd0);
    chk("midrst_idle", fifo_idle, 1'b1);
    chk("midrst_re", ram_re, 1'b0);
    chk("midrst_we", ram_we, 1'b0);
    repeat (2) tick();
    rstn = 1'b1;
    @(negedge clk);
    chk("midrst_release_prdy", wr_prdy, 1'b1);
    chk("midrst_release_pvld", rd_pvld, 1'b0);
    single_push_check("after_rst");

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
